// File: rtl/carrera_ctrl.sv
// Lap-timing race controller: synchronises the line sensor, sequences the race
// and latches cumulative split times from an external stopwatch.
module carrera_ctrl #(
  parameter int CLK_FREQ       = 25_000_000,
  parameter int NUM_LAPS       = 3,
  parameter int LOCKOUT_CYCLES = CLK_FREQ / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_arm,
  input  logic       btn_clear,
  input  logic       sensor_raw,
  input  logic [3:0] minutos,
  input  logic [5:0] segundos,
  input  logic [6:0] centesimas,
  output logic       timer_reset,
  output logic       timer_enable,
  output logic [1:0] state,
  output logic [2:0] lap_count,
  output logic [3:0] split_min,
  output logic [5:0] split_sec,
  output logic [6:0] split_cent,
  output logic       split_valid,
  output logic       dnf
);

  localparam int LW = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [2:0]    LAPS_MAX  = 3'(NUM_LAPS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    RUNNING  = 2'd2,
    FINISHED = 2'd3
  } state_t;

  state_t        st;
  logic          sync1, sync2, hist, evt;
  logic [LW-1:0] lockout;
  logic          lockout_zero;
  logic          timeout_hit;

  assign state        = st;
  assign lockout_zero = (lockout == '0);
  assign timeout_hit  = (minutos == 4'd9) && (segundos == 6'd59) && (centesimas == 7'd99);

  // History runs in every state so a sensor already high on arming never looks like a fresh rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      evt   <= 1'b0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
      hist  <= sync2;
      evt   <= sync2 & ~hist;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      timer_reset  <= 1'b1;
      timer_enable <= 1'b0;
      lap_count    <= 3'd0;
      split_min    <= 4'd0;
      split_sec    <= 6'd0;
      split_cent   <= 7'd0;
      split_valid  <= 1'b0;
      dnf          <= 1'b0;
      lockout      <= '0;
    end else begin
      split_valid <= 1'b0;
      if (btn_clear) begin
        st           <= IDLE;
        timer_reset  <= 1'b1;
        timer_enable <= 1'b0;
        lap_count    <= 3'd0;
        split_min    <= 4'd0;
        split_sec    <= 6'd0;
        split_cent   <= 7'd0;
        dnf          <= 1'b0;
        lockout      <= '0;
      end else begin
        case (st)
          IDLE: begin
            timer_reset  <= 1'b1;
            timer_enable <= 1'b0;
            if (btn_arm) begin
              st <= ARMED;
            end
          end
          ARMED: begin
            if (evt) begin
              st           <= RUNNING;
              lockout      <= LOCK_LOAD;
              timer_reset  <= 1'b0;
              timer_enable <= 1'b1;
            end
          end
          RUNNING: begin
            // A lap takes precedence over a simultaneous timeout.
            if (evt && lockout_zero) begin
              split_min   <= minutos;
              split_sec   <= segundos;
              split_cent  <= centesimas;
              split_valid <= 1'b1;
              lap_count   <= lap_count + 3'd1;
              lockout     <= LOCK_LOAD;
              if ((lap_count + 3'd1) == LAPS_MAX) begin
                st           <= FINISHED;
                timer_enable <= 1'b0;
              end
            end else begin
              if (!lockout_zero) begin
                lockout <= lockout - LW'(1);
              end
              if (timeout_hit) begin
                st           <= FINISHED;
                dnf          <= 1'b1;
                timer_enable <= 1'b0;
              end
            end
          end
          FINISHED: begin
            timer_reset  <= 1'b0;
            timer_enable <= 1'b0;
          end
          default: begin
            st           <= IDLE;
            timer_reset  <= 1'b1;
            timer_enable <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_carrera_ctrl.sv
// Directed bench for carrera_ctrl: a cycle-level race model is compared against
// the DUT on every falling edge, plus hand-computed literal expectations.
module tb_carrera_ctrl;
  localparam int NL = 3;
  localparam int LC = 10;

  logic       clk = 1'b0, reset = 1'b0;
  logic       btn_arm = 1'b0, btn_clear = 1'b0, sensor_raw = 1'b0;
  logic [3:0] minutos = 4'd0;
  logic [5:0] segundos = 6'd0;
  logic [6:0] centesimas = 7'd0;
  logic       timer_reset, timer_enable, split_valid, dnf;
  logic [1:0] state;
  logic [2:0] lap_count;
  logic [3:0] split_min;
  logic [5:0] split_sec;
  logic [6:0] split_cent;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Race model: state 0..3, a raw-sensor history and the cycle of the last accepted crossing.
  int m_state = 0, m_laps = 0, m_min = 0, m_sec = 0, m_cent = 0;
  bit m_valid = 1'b0, m_dnf = 1'b0;
  bit r1 = 1'b0, r2 = 1'b0, r3 = 1'b0, r4 = 1'b0;
  int cyc = 0, last_acc = 0;

  carrera_ctrl #(.CLK_FREQ(1000), .NUM_LAPS(NL), .LOCKOUT_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .btn_arm(btn_arm), .btn_clear(btn_clear),
    .sensor_raw(sensor_raw), .minutos(minutos), .segundos(segundos),
    .centesimas(centesimas), .timer_reset(timer_reset), .timer_enable(timer_enable),
    .state(state), .lap_count(lap_count), .split_min(split_min), .split_sec(split_sec),
    .split_cent(split_cent), .split_valid(split_valid), .dnf(dnf)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A crossing is seen by the controller three edges after the edge that first samples the rise.
  always @(posedge clk or posedge reset) begin
    bit ev, lap;
    if (reset) begin
      m_state = 0; m_laps = 0; m_min = 0; m_sec = 0; m_cent = 0;
      m_valid = 1'b0; m_dnf = 1'b0;
      r1 = 1'b0; r2 = 1'b0; r3 = 1'b0; r4 = 1'b0;
    end else begin
      ev = r3 && !r4;
      r4 = r3; r3 = r2; r2 = r1; r1 = sensor_raw;
      cyc++;
      m_valid = 1'b0;
      if (btn_clear) begin
        m_state = 0; m_laps = 0; m_min = 0; m_sec = 0; m_cent = 0; m_dnf = 1'b0;
      end else if (m_state == 0) begin
        if (btn_arm) m_state = 1;
      end else if (m_state == 1) begin
        if (ev) begin
          m_state = 2;
          last_acc = cyc;
        end
      end else if (m_state == 2) begin
        lap = ev && ((cyc - last_acc) > LC);
        if (lap) begin
          m_min = int'(minutos); m_sec = int'(segundos); m_cent = int'(centesimas);
          m_laps++;
          m_valid = 1'b1;
          last_acc = cyc;
          if (m_laps == NL) m_state = 3;
        end else if (minutos == 4'd9 && segundos == 6'd59 && centesimas == 7'd99) begin
          m_state = 3;
          m_dnf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("state", int'(state), m_state);
      cmp("timer_reset", int'(timer_reset), (m_state < 2) ? 1 : 0);
      cmp("timer_enable", int'(timer_enable), (m_state == 2) ? 1 : 0);
      cmp("lap_count", int'(lap_count), m_laps);
      cmp("split_min", int'(split_min), m_min);
      cmp("split_sec", int'(split_sec), m_sec);
      cmp("split_cent", int'(split_cent), m_cent);
      cmp("split_valid", int'(split_valid), int'(m_valid));
      cmp("dnf", int'(dnf), int'(m_dnf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_time(input int m, input int s, input int c);
    minutos = 4'(m); segundos = 6'(s); centesimas = 7'(c);
  endtask

  task automatic clear_pulse();
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
  endtask

  task automatic start_race();
    btn_arm = 1'b1; tick(); btn_arm = 1'b0;
    sensor_raw = 1'b1; tickn(4); sensor_raw = 1'b0;
    tickn(12);
  endtask

  task automatic do_lap(input int m, input int s, input int c);
    set_time(m, s, c);
    sensor_raw = 1'b1; tickn(4); sensor_raw = 1'b0;
    tickn(12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    chk_on = 1'b1;
    tickn(2);
    reset = 1'b0;
    @(negedge clk);
    cmp("lit_reset_state", int'(state), 0);
    cmp("lit_reset_treset", int'(timer_reset), 1);
    cmp("lit_reset_tenable", int'(timer_enable), 0);
    cmp("lit_reset_laps", int'(lap_count), 0);

    // Arm, then start: RUNNING exactly four edges after the sensor rise.
    tick();
    btn_arm = 1'b1; tick(); btn_arm = 1'b0;
    @(negedge clk);
    cmp("lit_armed", int'(state), 1);
    sensor_raw = 1'b1;
    tickn(3);
    @(negedge clk);
    cmp("lit_start_not_yet", int'(state), 1);
    tick();
    @(negedge clk);
    cmp("lit_start_state", int'(state), 2);
    cmp("lit_start_tenable", int'(timer_enable), 1);
    cmp("lit_start_treset", int'(timer_reset), 0);

    // Second rise inside the lockout window is ignored.
    tick(); sensor_raw = 1'b0;
    tickn(2); sensor_raw = 1'b1;
    tickn(3); sensor_raw = 1'b0;
    tickn(6);
    @(negedge clk);
    cmp("lit_lockout_laps", int'(lap_count), 0);
    tickn(8);

    // First lap at 0:12.34.
    set_time(0, 12, 34);
    sensor_raw = 1'b1;
    tickn(4);
    @(negedge clk);
    cmp("lit_lap1_valid", int'(split_valid), 1);
    cmp("lit_lap1_min", int'(split_min), 0);
    cmp("lit_lap1_sec", int'(split_sec), 12);
    cmp("lit_lap1_cent", int'(split_cent), 34);
    cmp("lit_lap1_laps", int'(lap_count), 1);
    tick();
    @(negedge clk);
    cmp("lit_lap1_valid_off", int'(split_valid), 0);
    sensor_raw = 1'b0;
    tickn(12);

    do_lap(0, 20, 0);
    @(negedge clk);
    cmp("lit_lap2_laps", int'(lap_count), 2);

    // Final lap: timer_enable drops on the lap edge.
    set_time(0, 30, 50);
    sensor_raw = 1'b1;
    tickn(3);
    @(negedge clk);
    cmp("lit_lap3_enable_before", int'(timer_enable), 1);
    tick();
    @(negedge clk);
    cmp("lit_fin_state", int'(state), 3);
    cmp("lit_fin_tenable", int'(timer_enable), 0);
    cmp("lit_fin_dnf", int'(dnf), 0);
    cmp("lit_fin_sec", int'(split_sec), 30);
    cmp("lit_fin_cent", int'(split_cent), 50);
    cmp("lit_fin_laps", int'(lap_count), 3);
    sensor_raw = 1'b0;

    // FINISHED ignores arm and sensor.
    tick();
    btn_arm = 1'b1; tick(); btn_arm = 1'b0;
    do_lap(1, 0, 0);
    @(negedge clk);
    cmp("lit_hold_state", int'(state), 3);
    cmp("lit_hold_sec", int'(split_sec), 30);

    // Timeout without a lap -> DNF.
    clear_pulse();
    @(negedge clk);
    cmp("lit_clear_state", int'(state), 0);
    cmp("lit_clear_laps", int'(lap_count), 0);
    cmp("lit_clear_sec", int'(split_sec), 0);
    start_race();
    set_time(9, 59, 99);
    tick();
    set_time(0, 0, 0);
    @(negedge clk);
    cmp("lit_dnf_state", int'(state), 3);
    cmp("lit_dnf_flag", int'(dnf), 1);
    cmp("lit_dnf_laps", int'(lap_count), 0);

    // Final lap coincides with the timeout: the lap wins.
    clear_pulse();
    start_race();
    do_lap(0, 10, 0);
    do_lap(0, 20, 0);
    set_time(1, 0, 0);
    sensor_raw = 1'b1;
    tickn(3);
    set_time(9, 59, 99);
    tick();
    @(negedge clk);
    cmp("lit_tie_state", int'(state), 3);
    cmp("lit_tie_dnf", int'(dnf), 0);
    cmp("lit_tie_laps", int'(lap_count), NL);
    cmp("lit_tie_min", int'(split_min), 9);
    set_time(0, 0, 0);
    sensor_raw = 1'b0;

    // Clear coincident with a lap event.
    clear_pulse();
    start_race();
    set_time(0, 5, 5);
    sensor_raw = 1'b1;
    tickn(3);
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
    @(negedge clk);
    cmp("lit_clr_state", int'(state), 0);
    cmp("lit_clr_laps", int'(lap_count), 0);
    cmp("lit_clr_valid", int'(split_valid), 0);
    cmp("lit_clr_treset", int'(timer_reset), 1);
    sensor_raw = 1'b0;
    tick();
    @(negedge clk);
    cmp("lit_clr_valid_next", int'(split_valid), 0);

    // Sensor held high through arming must not start the race.
    sensor_raw = 1'b1;
    tickn(5);
    btn_arm = 1'b1; tick(); btn_arm = 1'b0;
    tickn(6);
    @(negedge clk);
    cmp("lit_held_armed", int'(state), 1);
    sensor_raw = 1'b0;
    tickn(4);
    @(negedge clk);
    cmp("lit_held_fall", int'(state), 1);
    sensor_raw = 1'b1;
    tickn(4);
    @(negedge clk);
    cmp("lit_held_rise", int'(state), 2);
    sensor_raw = 1'b0;

    // Asynchronous reset mid-race.
    tickn(3);
    reset = 1'b1;
    #1;
    cmp("lit_async_state", int'(state), 0);
    cmp("lit_async_tenable", int'(timer_enable), 0);
    cmp("lit_async_treset", int'(timer_reset), 1);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    cmp("lit_after_reset", int'(state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
